// File: rtl/switch_ctrl_if.sv
// Switch/lamp bundle between the board switch pins and the lamp controller.
// The master side is the controller; the slave side drives the raw switches.
interface switch_ctrl_if #(
    parameter int unsigned CNT_W = 8
);
    logic             a_raw;
    logic             b_raw;
    logic             f;
    logic             k;
    logic             toggle_pulse;
    logic [CNT_W-1:0] toggle_cnt;
    logic             timeout;
    logic             busy;

    modport master (
        input  a_raw, b_raw,
        output f, k, toggle_pulse, toggle_cnt, timeout, busy
    );

    modport slave (
        output a_raw, b_raw,
        input  f, k, toggle_pulse, toggle_cnt, timeout, busy
    );
endinterface

// File: rtl/switch_ctrl.sv
// Two-way lamp switch controller: sync + debounce two switches, toggle lamp per event.
// Optional idle auto-off is built when SWITCH_CTRL_AUTOOFF_EN is defined.
module switch_ctrl #(
    parameter int unsigned DB_CYCLES  = 4,
    parameter int unsigned OFF_CYCLES = 16,
    parameter int unsigned CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    switch_ctrl_if.master    sw
);
    localparam int unsigned DB_W = $clog2(DB_CYCLES + 1);

    typedef enum logic {
        ST_OFF = 1'b0,
        ST_ON  = 1'b1
    } state_t;

    if (DB_CYCLES < 1 || OFF_CYCLES < 1) begin : g_bad_param
        $error("switch_ctrl: DB_CYCLES and OFF_CYCLES must be >= 1");
    end

    // Index 0 is switch A, index 1 is switch B.
    logic [1:0]            raw_c;
    logic [1:0]            s1;
    logic [1:0]            s2;
    logic [1:0]            db;
    logic [1:0]            db_next;
    logic [1:0][DB_W-1:0]  db_cnt;
    logic [1:0][DB_W-1:0]  db_cnt_next;
    logic [1:0]            ev_c;
    logic                  ev_q;
    logic [1:0]            n_q;

    state_t                state;
    state_t                state_next;
    logic                  toggle_pulse_q;
    logic [CNT_W-1:0]      toggle_cnt_q;
    logic                  fire_c;

    assign raw_c = {sw.b_raw, sw.a_raw};

    // Two-flop synchronizer per switch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= raw_c;
            s2 <= s1;
        end
    end

    // Debounce: accept a change only after DB_CYCLES consecutive differing samples.
    always_comb begin
        db_next     = db;
        db_cnt_next = '0;
        for (int i = 0; i < 2; i++) begin
            if (s2[i] != db[i]) begin
                if (db_cnt[i] == DB_W'(DB_CYCLES - 1)) begin
                    db_next[i] = s2[i];
                end else begin
                    db_cnt_next[i] = db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    assign ev_c = db_next ^ db;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db     <= '0;
            db_cnt <= '0;
            ev_q   <= 1'b0;
            n_q    <= '0;
        end else begin
            db     <= db_next;
            db_cnt <= db_cnt_next;
            ev_q   <= |ev_c;
            n_q    <= 2'(ev_c[0]) + 2'(ev_c[1]);
        end
    end

`ifdef SWITCH_CTRL_AUTOOFF_EN
    localparam int unsigned OFF_W = $clog2(OFF_CYCLES + 1);

    logic [OFF_W-1:0] idle_cnt;
    logic [OFF_W-1:0] idle_cnt_next;
    logic             timeout_q;

    // Lamp FSM; a switch event takes priority over the idle timeout.
    always_comb begin
        state_next    = state;
        fire_c        = 1'b0;
        idle_cnt_next = '0;
        if (ev_q) begin
            if (n_q == 2'd1) begin
                state_next = (state == ST_ON) ? ST_OFF : ST_ON;
            end
        end else if (state == ST_ON) begin
            if (idle_cnt == OFF_W'(OFF_CYCLES - 1)) begin
                state_next = ST_OFF;
                fire_c     = 1'b1;
            end else begin
                idle_cnt_next = idle_cnt + OFF_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            idle_cnt  <= idle_cnt_next;
            timeout_q <= fire_c;
        end
    end

    assign sw.timeout = timeout_q;
`else
    // Lamp FSM without timer: lamp tracks the XOR of the debounced switches.
    always_comb begin
        state_next = state;
        fire_c     = 1'b0;
        if (ev_q && (n_q == 2'd1)) begin
            state_next = (state == ST_ON) ? ST_OFF : ST_ON;
        end
    end

    assign sw.timeout = fire_c;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_OFF;
            toggle_pulse_q <= 1'b0;
            toggle_cnt_q   <= '0;
        end else begin
            state          <= state_next;
            toggle_pulse_q <= ev_q;
            toggle_cnt_q   <= toggle_cnt_q + CNT_W'(n_q);
        end
    end

    assign sw.f            = (state == ST_ON);
    assign sw.k            = |db;
    assign sw.busy         = |db_cnt;
    assign sw.toggle_pulse = toggle_pulse_q;
    assign sw.toggle_cnt   = toggle_cnt_q;

endmodule

// File: tb/tb_switch_ctrl.sv
// Directed self-checking bench for switch_ctrl (default CNT_W=8 plus a CNT_W=2 copy for wrap).
// Auto-off expectations follow SWITCH_CTRL_AUTOOFF_EN.
module tb_switch_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    switch_ctrl_if #(.CNT_W(8)) bus  ();
    switch_ctrl_if #(.CNT_W(2)) bus2 ();

    assign bus2.a_raw = bus.a_raw;
    assign bus2.b_raw = bus.b_raw;

    switch_ctrl #(.DB_CYCLES(4), .OFF_CYCLES(16), .CNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sw    (bus.master)
    );

    switch_ctrl #(.DB_CYCLES(4), .OFF_CYCLES(16), .CNT_W(2)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .sw    (bus2.master)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        bus.a_raw = 1'b0;
        bus.b_raw = 1'b0;
        rst_n     = 1'b0;
        tick(2);
        rst_n     = 1'b1;
    endtask

    task automatic test_reset();
        bus.a_raw = 1'b0;
        bus.b_raw = 1'b0;
        tick(2);
        checks++;
        if ({bus.f, bus.k, bus.toggle_pulse, bus.timeout, bus.busy} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b want 00000",
                     {bus.f, bus.k, bus.toggle_pulse, bus.timeout, bus.busy});
        end
        checks++;
        if (bus.toggle_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_cnt: got %0d want 0", bus.toggle_cnt);
        end
    endtask

    task automatic test_basic();
        rst_n     = 1'b1;
        bus.a_raw = 1'b1;
        tick(5);
        checks++;
        if ({bus.busy, bus.k} !== 2'b10) begin
            errors++;
            $display("FAIL basic_debouncing: busy,k got %b want 10", {bus.busy, bus.k});
        end
        tick(1);
        checks++;
        if ({bus.k, bus.f, bus.busy} !== 3'b100) begin
            errors++;
            $display("FAIL basic_db_E5: k,f,busy got %b want 100", {bus.k, bus.f, bus.busy});
        end
        tick(1);
        checks++;
        if ({bus.f, bus.toggle_pulse} !== 2'b11 || bus.toggle_cnt !== 8'd1) begin
            errors++;
            $display("FAIL basic_a_E6: f,pulse got %b cnt %0d want 11 cnt 1",
                     {bus.f, bus.toggle_pulse}, bus.toggle_cnt);
        end
        tick(1);
        checks++;
        if (bus.toggle_pulse !== 1'b0) begin
            errors++;
            $display("FAIL basic_pulse_width: got %b want 0", bus.toggle_pulse);
        end
        bus.b_raw = 1'b1;
        tick(7);
        checks++;
        if ({bus.f, bus.k, bus.toggle_pulse} !== 3'b011 || bus.toggle_cnt !== 8'd2) begin
            errors++;
            $display("FAIL basic_b: f,k,pulse got %b cnt %0d want 011 cnt 2",
                     {bus.f, bus.k, bus.toggle_pulse}, bus.toggle_cnt);
        end
    endtask

    task automatic test_bounce();
        do_reset();
        bus.a_raw = 1'b1;
        tick(3);
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL bounce_busy_high: got %b want 1", bus.busy);
        end
        bus.a_raw = 1'b0;
        tick(10);
        checks++;
        if ({bus.busy, bus.f, bus.k} !== 3'b000 || bus.toggle_cnt !== 8'd0) begin
            errors++;
            $display("FAIL bounce_rejected: busy,f,k got %b cnt %0d want 000 cnt 0",
                     {bus.busy, bus.f, bus.k}, bus.toggle_cnt);
        end
        bus.a_raw = 1'b1;
        tick(4);
        bus.a_raw = 1'b0;
        tick(3);
        checks++;
        if ({bus.f, bus.toggle_pulse, bus.k} !== 3'b111 || bus.toggle_cnt !== 8'd1) begin
            errors++;
            $display("FAIL bounce_4cyc_accept: f,pulse,k got %b cnt %0d want 111 cnt 1",
                     {bus.f, bus.toggle_pulse, bus.k}, bus.toggle_cnt);
        end
        tick(3);
        checks++;
        if ({bus.k, bus.f} !== 2'b01) begin
            errors++;
            $display("FAIL bounce_fall_db: k,f got %b want 01", {bus.k, bus.f});
        end
        tick(1);
        checks++;
        if (bus.f !== 1'b0 || bus.toggle_cnt !== 8'd2) begin
            errors++;
            $display("FAIL bounce_fall_event: f %b cnt %0d want f 0 cnt 2", bus.f, bus.toggle_cnt);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        bus.a_raw = 1'b1;
        bus.b_raw = 1'b1;
        tick(7);
        checks++;
        if ({bus.toggle_pulse, bus.f, bus.k} !== 3'b101 || bus.toggle_cnt !== 8'd2) begin
            errors++;
            $display("FAIL simul_event: pulse,f,k got %b cnt %0d want 101 cnt 2",
                     {bus.toggle_pulse, bus.f, bus.k}, bus.toggle_cnt);
        end
        tick(1);
        checks++;
        if (bus.toggle_pulse !== 1'b0 || bus.toggle_cnt !== 8'd2) begin
            errors++;
            $display("FAIL simul_single_pulse: pulse %b cnt %0d want 0 cnt 2",
                     bus.toggle_pulse, bus.toggle_cnt);
        end
    endtask

    task automatic test_independent();
        do_reset();
        bus.a_raw = 1'b1;
        tick(2);
        bus.b_raw = 1'b1;
        tick(5);
        checks++;
        if ({bus.f, bus.toggle_pulse} !== 2'b11 || bus.toggle_cnt !== 8'd1) begin
            errors++;
            $display("FAIL indep_a: f,pulse got %b cnt %0d want 11 cnt 1",
                     {bus.f, bus.toggle_pulse}, bus.toggle_cnt);
        end
        tick(1);
        checks++;
        if (bus.toggle_pulse !== 1'b0) begin
            errors++;
            $display("FAIL indep_gap: pulse got %b want 0", bus.toggle_pulse);
        end
        tick(1);
        checks++;
        if ({bus.f, bus.toggle_pulse} !== 2'b01 || bus.toggle_cnt !== 8'd2) begin
            errors++;
            $display("FAIL indep_b: f,pulse got %b cnt %0d want 01 cnt 2",
                     {bus.f, bus.toggle_pulse}, bus.toggle_cnt);
        end
    endtask

    task automatic test_wrap();
        logic [1:0] wrap_exp [5];
        logic [7:0] full_exp;
        wrap_exp[0] = 2'd1;
        wrap_exp[1] = 2'd2;
        wrap_exp[2] = 2'd3;
        wrap_exp[3] = 2'd0;
        wrap_exp[4] = 2'd1;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            bus.a_raw = ~bus.a_raw;
            tick(7);
            full_exp = 8'(i + 1);
            checks++;
            if (bus2.toggle_cnt !== wrap_exp[i] || bus.toggle_cnt !== full_exp) begin
                errors++;
                $display("FAIL wrap_%0d: cnt2 %0d cnt8 %0d want %0d and %0d",
                         i, bus2.toggle_cnt, bus.toggle_cnt, wrap_exp[i], full_exp);
            end
        end
    endtask

    task automatic test_autooff();
        do_reset();
        bus.a_raw = 1'b1;
        tick(7);
        checks++;
        if (bus.f !== 1'b1) begin
            errors++;
            $display("FAIL autooff_on: f got %b want 1", bus.f);
        end
`ifdef SWITCH_CTRL_AUTOOFF_EN
        tick(15);
        checks++;
        if ({bus.f, bus.timeout} !== 2'b10) begin
            errors++;
            $display("FAIL autooff_before: f,timeout got %b want 10", {bus.f, bus.timeout});
        end
        tick(1);
        checks++;
        if ({bus.f, bus.timeout} !== 2'b01) begin
            errors++;
            $display("FAIL autooff_fire: f,timeout got %b want 01", {bus.f, bus.timeout});
        end
        tick(1);
        checks++;
        if ({bus.f, bus.timeout} !== 2'b00) begin
            errors++;
            $display("FAIL autooff_after: f,timeout got %b want 00", {bus.f, bus.timeout});
        end
        bus.b_raw = 1'b1;
        tick(7);
        checks++;
        if ({bus.f, bus.toggle_pulse} !== 2'b11) begin
            errors++;
            $display("FAIL autooff_reon: f,pulse got %b want 11", {bus.f, bus.toggle_pulse});
        end
        tick(9);
        bus.a_raw = 1'b0;
        tick(7);
        checks++;
        if ({bus.f, bus.timeout, bus.toggle_pulse} !== 3'b001 || bus.toggle_cnt !== 8'd3) begin
            errors++;
            $display("FAIL autooff_ev_wins: f,timeout,pulse got %b cnt %0d want 001 cnt 3",
                     {bus.f, bus.timeout, bus.toggle_pulse}, bus.toggle_cnt);
        end
        tick(1);
        checks++;
        if ({bus.f, bus.timeout} !== 2'b00) begin
            errors++;
            $display("FAIL autooff_ev_after: f,timeout got %b want 00", {bus.f, bus.timeout});
        end
`else
        tick(40);
        checks++;
        if ({bus.f, bus.timeout} !== 2'b10) begin
            errors++;
            $display("FAIL no_autooff_hold: f,timeout got %b want 10", {bus.f, bus.timeout});
        end
`endif
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.a_raw = 1'b1;
        tick(3);
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL midrst_busy: got %b want 1", bus.busy);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.f, bus.k, bus.toggle_pulse, bus.timeout, bus.busy} !== 5'b0 ||
            bus.toggle_cnt !== 8'd0) begin
            errors++;
            $display("FAIL midrst_clear: flags %b cnt %0d want 00000 cnt 0",
                     {bus.f, bus.k, bus.toggle_pulse, bus.timeout, bus.busy}, bus.toggle_cnt);
        end
        tick(2);
        rst_n = 1'b1;
        tick(6);
        checks++;
        if ({bus.f, bus.toggle_pulse} !== 2'b00) begin
            errors++;
            $display("FAIL midrst_E5: f,pulse got %b want 00", {bus.f, bus.toggle_pulse});
        end
        tick(1);
        checks++;
        if ({bus.f, bus.toggle_pulse} !== 2'b11 || bus.toggle_cnt !== 8'd1) begin
            errors++;
            $display("FAIL midrst_E6: f,pulse got %b cnt %0d want 11 cnt 1",
                     {bus.f, bus.toggle_pulse}, bus.toggle_cnt);
        end
    endtask

    initial begin
        bus.a_raw = 1'b0;
        bus.b_raw = 1'b0;
        test_reset();
        test_basic();
        test_bounce();
        test_simultaneous();
        test_independent();
        test_wrap();
        test_autooff();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
